// File: rtl/rom_dl_splitter.sv
// Buffers the 16-bit ioctl download stream in a 2-word FIFO and re-issues each word
// as two region-decoded byte write strobes carrying region-relative offsets.
module rom_dl_splitter #(
    parameter logic [26:0] R0_BASE = 27'h00000,
    parameter logic [26:0] R0_SIZE = 27'h29000,
    parameter logic [26:0] R1_BASE = 27'h29000,
    parameter logic [26:0] R1_SIZE = 27'h04000,
    parameter logic [26:0] R2_BASE = 27'h2D000,
    parameter logic [26:0] R2_SIZE = 27'h20000,
    parameter logic [26:0] R3_BASE = 27'h4D000,
    parameter logic [26:0] R3_SIZE = 27'h08000,
    parameter int unsigned WR_GAP  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic        dl_wr,
    output logic [3:0]  dl_region,
    output logic [26:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_done,
    output logic        dl_overflow
);

    typedef enum logic [2:0] {IDLE, LO, GAP_LO, HI, GAP_HI, DONE} state_t;

    typedef struct packed {
        logic [3:0]  region;
        logic [26:0] off;
    } dec_t;

    localparam logic [3:0] GAP_LAST = 4'(WR_GAP - 1);

    state_t      state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic [41:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        push, pop, full, ovf_evt;
    logic [41:0] head;
    logic [25:0] work_addr_q;
    logic [7:0]  work_hi_q;
    logic        active_q, active_d;

    logic        wait_q, wr_q, done_q, ovf_q;
    logic [3:0]  region_q, region_d;
    logic [26:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_d, done_d;

    logic        issue_lo, issue_hi, end_word;
    logic [26:0] byte_addr;
    logic [7:0]  byte_data;
    dec_t        dec;
    logic        unused_addr_lsb;

    // Windows are compared at 28 bits so base+size never wraps.
    function automatic logic in_win(input logic [26:0] a, input logic [26:0] base,
                                    input logic [26:0] size);
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
    endfunction

    function automatic dec_t decode(input logic [26:0] a);
        dec_t r;
        r.region = '0;
        r.off    = '0;
        if (in_win(a, R0_BASE, R0_SIZE)) begin
            r.region = 4'b0001;
            r.off    = a - R0_BASE;
        end else if (in_win(a, R1_BASE, R1_SIZE)) begin
            r.region = 4'b0010;
            r.off    = a - R1_BASE;
        end else if (in_win(a, R2_BASE, R2_SIZE)) begin
            r.region = 4'b0100;
            r.off    = a - R2_BASE;
        end else if (in_win(a, R3_BASE, R3_SIZE)) begin
            r.region = 4'b1000;
            r.off    = a - R3_BASE;
        end
        return r;
    endfunction

    always_comb begin
        unused_addr_lsb = ioctl_addr[0];
        full    = (count_q == 2'd2);
        push    = ioctl_wr && ioctl_download && !full;
        ovf_evt = ioctl_wr && ioctl_download && full;
        head    = fifo_q[rd_ptr_q];
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        pop      = 1'b0;
        active_d = active_q || push;
        issue_lo = 1'b0;
        issue_hi = 1'b0;
        end_word = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    issue_lo = 1'b1;
                    state_d  = LO;
                end else if (!ioctl_download && active_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            LO: begin
                if (WR_GAP == 0) begin
                    issue_hi = 1'b1;
                    state_d  = HI;
                end else begin
                    gap_d   = '0;
                    state_d = GAP_LO;
                end
            end
            GAP_LO: begin
                if (gap_q == GAP_LAST) begin
                    issue_hi = 1'b1;
                    state_d  = HI;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            HI: begin
                if (WR_GAP == 0) begin
                    end_word = 1'b1;
                end else begin
                    gap_d   = '0;
                    state_d = GAP_HI;
                end
            end
            GAP_HI: begin
                if (gap_q == GAP_LAST) end_word = 1'b1;
                else gap_d = gap_q + 4'd1;
            end
            DONE: begin
                state_d  = IDLE;
                active_d = push;
            end
            default: state_d = IDLE;
        endcase
        // IDLE's pop decision is folded into the end of a word so words issue back-to-back.
        if (end_word) begin
            if (count_q != '0) begin
                pop      = 1'b1;
                issue_lo = 1'b1;
                state_d  = LO;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        byte_addr = {work_addr_q, 1'b1};
        byte_data = work_hi_q;
        if (issue_lo) begin
            byte_addr = {head[41:16], 1'b0};
            byte_data = head[7:0];
        end
        dec      = decode(byte_addr);
        wr_d     = 1'b0;
        region_d = region_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (issue_lo || issue_hi) begin
            region_d = dec.region;
            if (dec.region != '0) begin
                wr_d   = 1'b1;
                addr_d = dec.off;
                data_d = byte_data;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wr_ptr_q] <= {ioctl_addr[26:1], ioctl_dout};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            active_q    <= 1'b0;
            work_addr_q <= '0;
            work_hi_q   <= '0;
            wait_q      <= 1'b0;
            wr_q        <= 1'b0;
            region_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            active_q <= active_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                work_addr_q <= head[41:16];
                work_hi_q   <= head[15:8];
            end
            wait_q   <= (count_q != '0);
            wr_q     <= wr_d;
            region_q <= region_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_q || ovf_evt;
        end
    end

    always_comb begin
        ioctl_wait  = wait_q;
        dl_wr       = wr_q;
        dl_region   = region_q;
        dl_addr     = addr_q;
        dl_data     = data_q;
        dl_done     = done_q;
        dl_overflow = ovf_q;
    end

endmodule

// File: tb/tb_rom_dl_splitter.sv
// Scoreboard bench for rom_dl_splitter: instance a uses WR_GAP=2, instance b WR_GAP=0.
module tb_rom_dl_splitter;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        dl_wr, dl_done, dl_overflow;
    logic [3:0]  dl_region;
    logic [26:0] dl_addr;
    logic [7:0]  dl_data;

    logic        b_download, b_wr, b_wait;
    logic [26:0] b_addr;
    logic [15:0] b_dout;
    logic        b_dl_wr, b_done, b_ovf;
    logic [3:0]  b_region;
    logic [26:0] b_dl_addr;
    logic [7:0]  b_data;

    rom_dl_splitter #(.WR_GAP(2)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait), .dl_wr(dl_wr), .dl_region(dl_region),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_done(dl_done),
        .dl_overflow(dl_overflow)
    );

    rom_dl_splitter #(.WR_GAP(0)) u_dut0 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(b_download),
        .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_wr(b_wr),
        .ioctl_wait(b_wait), .dl_wr(b_dl_wr), .dl_region(b_region),
        .dl_addr(b_dl_addr), .dl_data(b_data), .dl_done(b_done),
        .dl_overflow(b_ovf)
    );

    typedef struct {
        logic [3:0]  region;
        logic [26:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [26:0] addr;
        logic [15:0] dout;
        logic        hit;
        logic [3:0]  region;
        logic [26:0] off;
    } vec_t;

    exp_t exp_q[$];
    exp_t expb_q[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int n_strobe = 0, n_done = 0, last_strobe_cyc = 0, done_cyc = 0;
    int b_strobe = 0, b_ndone = 0, b_last_strobe = 0, b_done_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    exp_t ea, eb;
    always @(negedge clk_sys) begin
        if (dl_wr) begin
            n_strobe++;
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_strobe: got addr %0h data %0h expected none (cycle %0d)",
                         dl_addr, dl_data, cyc);
            end else begin
                ea = exp_q.pop_front();
                chk("a_region", dl_region, ea.region);
                chk("a_addr", dl_addr, ea.addr);
                chk("a_data", dl_data, ea.data);
                if (ea.cyc >= 0) chk("a_strobe_cycle", cyc, ea.cyc);
            end
        end
        if (dl_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (b_dl_wr) begin
            b_strobe++;
            b_last_strobe = cyc;
            if (expb_q.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_strobe: got addr %0h data %0h expected none (cycle %0d)",
                         b_dl_addr, b_data, cyc);
            end else begin
                eb = expb_q.pop_front();
                chk("b_region", b_region, eb.region);
                chk("b_addr", b_dl_addr, eb.addr);
                chk("b_data", b_data, eb.data);
            end
        end
        if (b_done) begin
            b_ndone++;
            b_done_cyc = cyc;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_done_a(input int d0, input string nm);
        int guard;
        guard = 0;
        while (n_done == d0 && guard < 40) begin
            step();
            guard++;
        end
        chk(nm, n_done - d0, 1);
    endtask

    vec_t vecs[8];
    int   t, s0, d0, sent, guard;
    logic [7:0] lo_b, hi_b;

    initial begin
        vecs[0] = '{27'h29000,   16'hA55A, 1'b1, 4'b0010, 27'h00000};
        vecs[1] = '{27'h28FFE,   16'h1234, 1'b1, 4'b0001, 27'h28FFE};
        vecs[2] = '{27'h2CFFE,   16'hBEEF, 1'b1, 4'b0010, 27'h03FFE};
        vecs[3] = '{27'h55000,   16'hC3C3, 1'b0, 4'b0000, 27'h00000};
        vecs[4] = '{27'h2D001,   16'h7788, 1'b1, 4'b0100, 27'h00000};
        vecs[5] = '{27'h54FFE,   16'h0F0E, 1'b1, 4'b1000, 27'h07FFE};
        vecs[6] = '{27'h4CFFE,   16'h6655, 1'b1, 4'b0100, 27'h1FFFE};
        vecs[7] = '{27'h7FFFFFE, 16'h0102, 1'b0, 4'b0000, 27'h00000};

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        b_download = 1'b0; b_wr = 1'b0; b_addr = '0; b_dout = '0;
        repeat (3) step();
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_wr", dl_wr, 0);
        chk("rst_region", dl_region, 0);
        chk("rst_addr", dl_addr, 0);
        chk("rst_data", dl_data, 0);
        chk("rst_done", dl_done, 0);
        chk("rst_ovf", dl_overflow, 0);
        chk("rst_b_outputs", {b_wait, b_dl_wr, b_region, b_dl_addr, b_data, b_done, b_ovf}, 0);
        reset = 1'b0;
        step();

        // Single words, region boundaries, misses and timing.
        ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            t = cyc;
            ioctl_addr = vecs[i].addr;
            ioctl_dout = vecs[i].dout;
            ioctl_wr   = 1'b1;
            if (vecs[i].hit) begin
                exp_q.push_back('{vecs[i].region, vecs[i].off, vecs[i].dout[7:0], t + 2});
                exp_q.push_back('{vecs[i].region, vecs[i].off + 27'd1, vecs[i].dout[15:8], t + 5});
            end
            s0 = n_strobe;
            step();
            ioctl_wr = 1'b0;
            do @(negedge clk_sys); while (cyc < t + 2);
            chk("t1_wait_high", ioctl_wait, 1);
            if (!vecs[i].hit) begin
                chk("t1_miss_wr", dl_wr, 0);
                chk("t1_miss_region", dl_region, 0);
            end
            repeat (9) step();
            chk("t1_strobe_count", n_strobe - s0, vecs[i].hit ? 2 : 0);
            chk("t1_wait_low", ioctl_wait, 0);
        end
        d0 = n_done;
        ioctl_download = 1'b0;
        wait_done_a(d0, "t1_done");
        chk("t1_done_after_strobe", done_cyc > last_strobe_cyc, 1);
        repeat (10) step();
        chk("t1_single_done", n_done - d0, 1);

        // Download pulse with no words.
        s0 = n_strobe; d0 = n_done;
        ioctl_download = 1'b1;
        repeat (3) step();
        ioctl_download = 1'b0;
        repeat (12) step();
        chk("t6_no_strobe", n_strobe - s0, 0);
        chk("t6_no_done", n_done - d0, 0);

        // Three back-to-back words while the FSM is busy: two buffered, third dropped.
        ioctl_download = 1'b1;
        s0 = n_strobe;
        step();
        t = cyc;
        ioctl_addr = 27'h2D000; ioctl_dout = 16'h0201; ioctl_wr = 1'b1;
        exp_q.push_back('{4'b0100, 27'h0, 8'h01, t + 2});
        exp_q.push_back('{4'b0100, 27'h1, 8'h02, t + 5});
        step();
        ioctl_wr = 1'b0;
        step();
        ioctl_addr = 27'h2D002; ioctl_dout = 16'h0403; ioctl_wr = 1'b1;
        exp_q.push_back('{4'b0100, 27'h2, 8'h03, t + 8});
        exp_q.push_back('{4'b0100, 27'h3, 8'h04, t + 11});
        step();
        ioctl_addr = 27'h2D004; ioctl_dout = 16'h0605;
        exp_q.push_back('{4'b0100, 27'h4, 8'h05, t + 14});
        exp_q.push_back('{4'b0100, 27'h5, 8'h06, t + 17});
        step();
        ioctl_addr = 27'h2D006; ioctl_dout = 16'h0807;
        step();
        ioctl_wr = 1'b0;
        repeat (20) step();
        chk("t3_overflow", dl_overflow, 1);
        chk("t3_strobes", n_strobe - s0, 6);
        chk("t3_queue_empty", exp_q.size(), 0);
        d0 = n_done;
        ioctl_download = 1'b0;
        wait_done_a(d0, "t3_done");
        repeat (5) step();
        chk("t3_overflow_sticky", dl_overflow, 1);

        // Reset while in GAP_LO with one word still queued.
        ioctl_download = 1'b1;
        step();
        t = cyc;
        ioctl_addr = 27'h29010; ioctl_dout = 16'hCAFE; ioctl_wr = 1'b1;
        exp_q.push_back('{4'b0010, 27'h10, 8'hFE, t + 2});
        step();
        ioctl_addr = 27'h29012; ioctl_dout = 16'hBABE;
        step();
        ioctl_wr = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("t5_all_outputs_zero",
            {ioctl_wait, dl_wr, dl_region, dl_addr, dl_data, dl_done, dl_overflow}, 0);
        reset = 1'b0;
        s0 = n_strobe; d0 = n_done;
        repeat (15) step();
        ioctl_download = 1'b0;
        repeat (15) step();
        chk("t5_no_hi_byte", n_strobe - s0, 0);
        chk("t5_no_done", n_done - d0, 0);
        chk("t5_queue_empty", exp_q.size(), 0);

        // 64-word stream honouring ioctl_wait on the WR_GAP=0 instance.
        b_download = 1'b1;
        sent = 0; guard = 0;
        while (sent < 64 && guard < 3000) begin
            step();
            b_wr = 1'b0;
            if (!b_wait) begin
                lo_b = 8'(sent);
                hi_b = lo_b ^ 8'hA5;
                b_addr = 27'h2D000 + 27'(2 * sent);
                b_dout = {hi_b, lo_b};
                b_wr = 1'b1;
                expb_q.push_back('{4'b0100, 27'(2 * sent), lo_b, -1});
                expb_q.push_back('{4'b0100, 27'(2 * sent + 1), hi_b, -1});
                sent++;
            end
            guard++;
        end
        step();
        b_wr = 1'b0;
        guard = 0;
        while (expb_q.size() != 0 && guard < 400) begin
            step();
            guard++;
        end
        chk("t4_words_sent", sent, 64);
        chk("t4_strobes", b_strobe, 128);
        chk("t4_queue_empty", expb_q.size(), 0);
        chk("t4_no_overflow", b_ovf, 0);
        b_download = 1'b0;
        guard = 0;
        while (b_ndone == 0 && guard < 40) begin
            step();
            guard++;
        end
        repeat (10) step();
        chk("t4_one_done", b_ndone, 1);
        chk("t4_done_after_last", b_done_cyc > b_last_strobe, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
